// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage load/store unit: op codes, size codes,
// FSM states and small op-decoding helpers.
package mem_access_unit_pkg;

  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LBU = 3'd1;
  localparam logic [2:0] MEM_LH  = 3'd2;
  localparam logic [2:0] MEM_LHU = 3'd3;
  localparam logic [2:0] MEM_LW  = 3'd4;
  localparam logic [2:0] MEM_SB  = 3'd5;
  localparam logic [2:0] MEM_SH  = 3'd6;
  localparam logic [2:0] MEM_SW  = 3'd7;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ   = 3'd1,
    LSU_WAIT  = 3'd2,
    LSU_DONE  = 3'd3,
    LSU_DRAIN = 3'd4
  } lsu_state_e;

  function automatic logic is_store(input logic [2:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [2:0] op);
    logic [1:0] sz;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: sz = SIZE_B;
      MEM_LH, MEM_LHU, MEM_SH: sz = SIZE_H;
      default:                 sz = SIZE_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational data-path for the LSU: little-endian store replication/strobes
// and load byte/half extraction with sign or zero extension.
module mem_access_unit_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] sram_wdata,
  output logic [31:0] load_data
);

  logic [31:0] rdata_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    size       = op_size(op);
    wstrb      = 4'h0;
    sram_wdata = wdata;
    case (op)
      MEM_SB: begin
        sram_wdata = {4{wdata[7:0]}};
        wstrb      = 4'b0001 << addr_lo;
      end
      MEM_SH: begin
        sram_wdata = {2{wdata[15:0]}};
        wstrb      = 4'b0011 << addr_lo;
      end
      MEM_SW: wstrb = 4'hF;
      default: wstrb = 4'h0;
    endcase
  end

  // Halves are only ever aligned, so shifting by the byte offset serves both widths.
  always_comb begin
    rdata_sh = rdata >> {addr_lo, 3'b000};
    ld_byte  = rdata_sh[7:0];
    ld_half  = rdata_sh[15:0];
    case (op)
      MEM_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: load_data = {24'h0, ld_byte};
      MEM_LH:  load_data = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: load_data = {16'h0, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: alignment exceptions, split-handshake SRAM
// sequencing, load result capture and pipeline stall generation.
//
// state | meaning
// IDLE  | no access outstanding; request issued combinationally on start
// REQ   | address phase presented, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// DONE  | access complete; load result held while hold_M is high
// DRAIN | instruction flushed, discarding its outstanding response
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_M,
  input  logic [2:0]  mem_op_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  input  logic        flush_M,
  input  logic        hold_M,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        lsu_stall_M,
  output logic [31:0] load_data_M,
  output logic        load_valid_M,
  output logic        adel_M,
  output logic        ades_M,
  output logic [31:0] badvaddr_M
);

  lsu_state_e  state, state_n;
  logic        is_st, misalign, start;
  logic        req_c, stall_c, capture, clear_valid;
  logic [31:0] aligned_load;

  mem_access_unit_align u_align (
    .op         (mem_op_M),
    .addr_lo    (addr_M[1:0]),
    .wdata      (wdata_M),
    .rdata      (data_sram_rdata),
    .size       (data_sram_size),
    .wstrb      (data_sram_wstrb),
    .sram_wdata (data_sram_wdata),
    .load_data  (aligned_load)
  );

  always_comb begin
    is_st = is_store(mem_op_M);
    case (op_size(mem_op_M))
      SIZE_H:  misalign = addr_M[0];
      SIZE_W:  misalign = (addr_M[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    adel_M     = mem_en_M & ~is_st & misalign;
    ades_M     = mem_en_M & is_st & misalign;
    badvaddr_M = (adel_M | ades_M) ? addr_M : 32'h0;
    start      = mem_en_M & ~flush_M & ~adel_M & ~ades_M;
  end

  always_comb begin
    state_n     = state;
    req_c       = 1'b0;
    stall_c     = 1'b0;
    capture     = 1'b0;
    clear_valid = 1'b0;
    case (state)
      LSU_IDLE: begin
        req_c   = start;
        stall_c = start;
        if (start) state_n = data_sram_addr_ok ? LSU_WAIT : LSU_REQ;
      end
      LSU_REQ: begin
        stall_c = 1'b1;
        if (flush_M) begin
          state_n = LSU_IDLE;
        end else begin
          req_c = 1'b1;
          if (data_sram_addr_ok) state_n = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        stall_c = 1'b1;
        if (data_sram_data_ok) begin
          capture = 1'b1;
          state_n = LSU_DONE;
        end else if (flush_M) begin
          state_n = LSU_DRAIN;
        end
      end
      LSU_DONE: begin
        if (flush_M || !hold_M) begin
          state_n     = LSU_IDLE;
          clear_valid = 1'b1;
        end
      end
      LSU_DRAIN: begin
        // A younger op must wait until the stale response has been swallowed.
        stall_c = mem_en_M & ~flush_M;
        if (data_sram_data_ok) state_n = LSU_IDLE;
      end
      default: state_n = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LSU_IDLE;
      load_data_M  <= 32'h0;
      load_valid_M <= 1'b0;
    end else begin
      state <= state_n;
      if (capture && !is_st) begin
        load_data_M  <= aligned_load;
        load_valid_M <= 1'b1;
      end
      if (clear_valid) load_valid_M <= 1'b0;
    end
  end

  assign data_sram_req  = req_c & ~rst;
  assign lsu_stall_M    = stall_c & ~rst;
  assign data_sram_wr   = mem_en_M & is_st;
  assign data_sram_addr = addr_M;

endmodule
